rgb_to_lms: RTL and testbench

Pipelined colour-space stage that converts 8-bit RGB pixels to fixed-point LMS cone responses (unsigned 8.8) with a valid/ready stream handshake. Sits in the RGB2lab path directly upstream of the per-channel log2 stage; its L/M/S outputs are that stage's inputs. It also carries end-of-frame markers and counts accepted pixels per frame.

---
 rtl/rgb2lab_pkg.sv | 32 +++
 rtl/rgb_to_lms_row.sv | 67 ++++++
 rtl/rgb_to_lms.sv | 105 ++++++++++
 tb/tb_rgb_to_lms.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2lab_pkg.sv
// rgb2lab_pkg: shared constants for the RGB-to-Lab colour pipeline.
// Holds the RGB->LMS matrix coefficients (unsigned Q0.10, each equal to
// 1024 x the matrix entry, rounded), the LMS output format (unsigned 8.8)
// and the sum-to-output conversion. The downstream log2 stage imports
// the same package.
package rgb2lab_pkg;

  localparam int PIX_W     = 8;
  localparam int COEF_W    = 10;
  localparam int LMS_W     = 16;
  localparam int LMS_FRAC  = 8;
  localparam int SUM_W     = 18;
  localparam int SUM_SHIFT = 2;

  localparam logic [COEF_W-1:0] C_LR = 10'd390;
  localparam logic [COEF_W-1:0] C_LG = 10'd592;
  localparam logic [COEF_W-1:0] C_LB = 10'd41;
  localparam logic [COEF_W-1:0] C_MR = 10'd201;
  localparam logic [COEF_W-1:0] C_MG = 10'd742;
  localparam logic [COEF_W-1:0] C_MB = 10'd80;
  localparam logic [COEF_W-1:0] C_SR = 10'd25;
  localparam logic [COEF_W-1:0] C_SG = 10'd132;
  localparam logic [COEF_W-1:0] C_SB = 10'd865;

  // The exact 18-bit sum carries 10 fraction bits; dropping the low two
  // (truncation) gives 8.8. The largest sum, 255*1023, still fits in
  // 16 bits after the shift, so no clamp is needed.
  function automatic logic [LMS_W-1:0] sum_to_lms(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:SUM_SHIFT];
  endfunction

endpackage

// File: rtl/rgb_to_lms_row.sv
// lms_row: one row of the RGB->LMS matrix.
// Stage 1 registers the three 18-bit products, stage 2 registers the
// shifted sum. Both stages load on their enables; data loads even when
// the travelling valid is low (contents are don't-care then).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   en1_i, en2_i       stage 1 / stage 2 load enables
//   r_i, g_i, b_i      unsigned 8-bit pixel components
//   lms_o              unsigned 8.8 channel value (stage 2 register)
module lms_row
  import rgb2lab_pkg::*;
#(
  parameter logic [COEF_W-1:0] C0 = 10'd0,
  parameter logic [COEF_W-1:0] C1 = 10'd0,
  parameter logic [COEF_W-1:0] C2 = 10'd0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en1_i,
  input  logic             en2_i,
  input  logic [PIX_W-1:0] r_i,
  input  logic [PIX_W-1:0] g_i,
  input  logic [PIX_W-1:0] b_i,
  output logic [LMS_W-1:0] lms_o
);

  logic [SUM_W-1:0] prod_r_p1_d, prod_g_p1_d, prod_b_p1_d;
  logic [SUM_W-1:0] prod_r_p1_q, prod_g_p1_q, prod_b_p1_q;
  logic [SUM_W-1:0] sum_p2_d;
  logic [LMS_W-1:0] lms_p2_d, lms_p2_q;

  // Stage 1: 8x10 products, exact in 18 bits
  always_comb begin
    prod_r_p1_d = SUM_W'(r_i) * SUM_W'(C0);
    prod_g_p1_d = SUM_W'(g_i) * SUM_W'(C1);
    prod_b_p1_d = SUM_W'(b_i) * SUM_W'(C2);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_r_p1_q <= '0;
      prod_g_p1_q <= '0;
      prod_b_p1_q <= '0;
    end else if (en1_i) begin
      prod_r_p1_q <= prod_r_p1_d;
      prod_g_p1_q <= prod_g_p1_d;
      prod_b_p1_q <= prod_b_p1_d;
    end
  end

  // Stage 2: row sum (cannot overflow 18 bits) and shift to 8.8
  always_comb begin
    sum_p2_d = prod_r_p1_q + prod_g_p1_q + prod_b_p1_q;
    lms_p2_d = sum_to_lms(sum_p2_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lms_p2_q <= '0;
    end else if (en2_i) begin
      lms_p2_q <= lms_p2_d;
    end
  end

  assign lms_o = lms_p2_q;

endmodule

// File: rtl/rgb_to_lms.sv
// rgb_to_lms: two-stage pipelined RGB -> LMS conversion (unsigned 8.8)
// with a bubble-collapsing valid/ready handshake, end-of-frame marker
// pass-through and a saturating per-frame accepted-pixel counter.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-low reset
//   i_valid, o_ready        input handshake
//   i_r, i_g, i_b, i_last   input pixel and end-of-frame marker
//   o_valid, i_ready        output handshake
//   o_l, o_m, o_s, o_last   LMS triple and delayed end-of-frame marker
//   o_pix_cnt               pixels accepted so far in the current frame
module rgb_to_lms
  import rgb2lab_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [PIX_W-1:0] i_r,
  input  logic [PIX_W-1:0] i_g,
  input  logic [PIX_W-1:0] i_b,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [LMS_W-1:0] o_l,
  output logic [LMS_W-1:0] o_m,
  output logic [LMS_W-1:0] o_s,
  output logic             o_last,
  output logic [CNT_W-1:0] o_pix_cnt
);

  logic             vld_p1_q, vld_p2_q;
  logic             last_p1_q, last_p2_q;
  logic             en1, en2;
  logic             in_hs;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: restart on end of frame, otherwise count up and stick at
  // all-ones rather than wrap.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic hs,
                                                input logic last);
    if (!hs)
      return cnt;
    if (last)
      return '0;
    if (&cnt)
      return cnt;
    return cnt + 1'b1;
  endfunction

  // A stage may load when it is empty or when the stage after it moves;
  // this lets an empty stage absorb a pixel during a downstream stall.
  // o_ready therefore depends combinationally on i_ready.
  always_comb begin
    en2   = !vld_p2_q || i_ready;
    en1   = !vld_p1_q || en2;
    in_hs = i_valid && en1;
    cnt_d = cnt_next(cnt_q, in_hs, i_last);
  end

  assign o_ready = en1;

  // Stage 1 / stage 2 control registers and the frame counter
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (en1) begin
        vld_p1_q  <= i_valid;
        last_p1_q <= i_last;
      end
      if (en2) begin
        vld_p2_q  <= vld_p1_q;
        last_p2_q <= last_p1_q;
      end
      cnt_q <= cnt_d;
    end
  end

  lms_row #(.C0(C_LR), .C1(C_LG), .C2(C_LB)) u_row_l (
    .clk_i (i_clk), .rst_ni(i_rst), .en1_i(en1), .en2_i(en2),
    .r_i   (i_r),   .g_i   (i_g),   .b_i  (i_b), .lms_o(o_l)
  );

  lms_row #(.C0(C_MR), .C1(C_MG), .C2(C_MB)) u_row_m (
    .clk_i (i_clk), .rst_ni(i_rst), .en1_i(en1), .en2_i(en2),
    .r_i   (i_r),   .g_i   (i_g),   .b_i  (i_b), .lms_o(o_m)
  );

  lms_row #(.C0(C_SR), .C1(C_SG), .C2(C_SB)) u_row_s (
    .clk_i (i_clk), .rst_ni(i_rst), .en1_i(en1), .en2_i(en2),
    .r_i   (i_r),   .g_i   (i_g),   .b_i  (i_b), .lms_o(o_s)
  );

  assign o_valid   = vld_p2_q;
  assign o_last    = last_p2_q;
  assign o_pix_cnt = cnt_q;

endmodule

// File: tb/tb_rgb_to_lms.sv
// Testbench for rgb_to_lms: directed vectors with hand-computed values,
// a streamed run against an in-bench reference, frame marker / counter
// behaviour, mid-flight reset and counter saturation on a 3-bit instance.
module tb_rgb_to_lms;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready_out;
  logic [7:0]  r, g, b;
  logic        last;
  logic        ovalid;
  logic        rdy_in;
  logic [15:0] ol, om, os;
  logic        olast;
  logic [19:0] cnt;

  logic        rst3, valid3, last3, ready3, ovalid3, olast3;
  logic        rdy_in3;
  logic [15:0] ol3, om3, os3;
  logic [2:0]  cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rgb_to_lms #(.CNT_W(20)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_out),
    .i_r(r), .i_g(g), .i_b(b), .i_last(last),
    .o_valid(ovalid), .i_ready(rdy_in),
    .o_l(ol), .o_m(om), .o_s(os), .o_last(olast), .o_pix_cnt(cnt)
  );

  rgb_to_lms #(.CNT_W(3)) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_valid(valid3), .o_ready(ready3),
    .i_r(r), .i_g(g), .i_b(b), .i_last(last3),
    .o_valid(ovalid3), .i_ready(rdy_in3),
    .o_l(ol3), .o_m(om3), .o_s(os3), .o_last(olast3), .o_pix_cnt(cnt3)
  );

  // Reference: matrix row dot product, then drop 2 fraction bits.
  function automatic logic [15:0] lms_ref(input int ch, input int rr, input int gg, input int bb);
    int s;
    case (ch)
      0:       s = rr * 390 + gg * 592 + bb * 41;
      1:       s = rr * 201 + gg * 742 + bb * 80;
      default: s = rr * 25  + gg * 132 + bb * 865;
    endcase
    return 16'(s / 4);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; valid = 1'b0; last = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; valid = 1'b0; last = 1'b0; rdy_in = 1'b0;
    r = 8'd0; g = 8'd0; b = 8'd0;
    @(negedge clk);
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got %b want 0", ovalid); end
    n_checks++; if (olast !== 1'b0) begin n_fail++; $display("FAIL reset_o_last got %b want 0", olast); end
    n_checks++; if ({ol, om, os} !== 48'h0) begin n_fail++; $display("FAIL reset_lms got %h %h %h want 0", ol, om, os); end
    n_checks++; if (cnt !== 20'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    rst = 1'b1;
    #1;
    n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready got %b want 1", ready_out); end
  endtask

  task automatic test_single(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                             input logic [15:0] el, input logic [15:0] em, input logic [15:0] es,
                             input string name);
    @(negedge clk);
    rdy_in = 1'b1; valid = 1'b1; last = 1'b0; r = rr; g = gg; b = bb;
    @(negedge clk);
    valid = 1'b0;
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL %s early_valid got %b want 0", name, ovalid); end
    @(negedge clk);
    n_checks++; if (ovalid !== 1'b1) begin n_fail++; $display("FAIL %s o_valid got %b want 1", name, ovalid); end
    n_checks++; if ({ol, om, os} !== {el, em, es})
      begin n_fail++; $display("FAIL %s lms got %h %h %h want %h %h %h", name, ol, om, os, el, em, es); end
    @(negedge clk);
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL %s valid_width got %b want 0", name, ovalid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pr[10], pg[10], pb[10];
    logic [47:0] exp_q[$];
    logic [47:0] e;
    int sent = 0;
    int got  = 0;
    int occ;
    for (int i = 0; i < 10; i++) begin
      pr[i] = 8'($urandom_range(0, 255));
      pg[i] = 8'($urandom_range(0, 255));
      pb[i] = 8'($urandom_range(0, 255));
    end
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      @(negedge clk);
      rdy_in = (cyc >= 3 && cyc < 8) ? 1'b0 : ($urandom_range(0, 3) != 0);
      last = 1'b0;
      if (sent < 10) begin
        valid = 1'b1; r = pr[sent]; g = pg[sent]; b = pb[sent];
      end else begin
        valid = 1'b0;
      end
      #1;
      occ = sent - got;
      n_checks++;
      if (ready_out !== !(occ == 2 && !rdy_in)) begin
        n_fail++; $display("FAIL stream_o_ready cyc %0d got %b want %b", cyc, ready_out, !(occ == 2 && !rdy_in));
      end
      if (ovalid && rdy_in) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra_output got %h %h %h want none", ol, om, os);
        end else begin
          e = exp_q.pop_front();
          if ({ol, om, os} !== e) begin
            n_fail++; $display("FAIL stream_data pix %0d got %h want %h", got, {ol, om, os}, e);
          end
        end
        got++;
      end
      if (valid && ready_out) begin
        exp_q.push_back({lms_ref(0, int'(r), int'(g), int'(b)),
                         lms_ref(1, int'(r), int'(g), int'(b)),
                         lms_ref(2, int'(r), int'(g), int'(b))});
        sent++;
      end
    end
    n_checks++; if (got !== 10) begin n_fail++; $display("FAIL stream_count got %0d want 10", got); end
    @(negedge clk);
    valid = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic test_frame();
    int exp_cnt[4] = '{1, 2, 3, 0};
    do_reset();
    rdy_in = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      if (k >= 1 && k <= 4) begin
        n_checks++;
        if (cnt !== 20'(exp_cnt[k-1])) begin
          n_fail++; $display("FAIL frame_cnt step %0d got %0d want %0d", k, cnt, exp_cnt[k-1]);
        end
      end
      if (k >= 2 && k <= 5) begin
        n_checks++;
        if (ovalid !== 1'b1 || olast !== (k == 5)) begin
          n_fail++; $display("FAIL frame_last out %0d got valid %b last %b want valid 1 last %b", k - 2, ovalid, olast, (k == 5));
        end
      end
      if (k == 6) begin
        n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL frame_tail got %b want 0", ovalid); end
      end
      valid = (k < 4);
      last  = (k == 3);
      r = 8'(k * 20); g = 8'(k * 7); b = 8'(k * 3);
    end
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    rdy_in = 1'b0; valid = 1'b1; last = 1'b0; r = 8'd100; g = 8'd50; b = 8'd25;
    @(negedge clk);
    r = 8'd10;
    @(negedge clk);
    valid = 1'b0;
    n_checks++; if (ovalid !== 1'b1 || ready_out !== 1'b0)
      begin n_fail++; $display("FAIL midrst_full got valid %b ready %b want 1 0", ovalid, ready_out); end
    rst = 1'b0;
    #1;
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL midrst_o_valid got %b want 0", ovalid); end
    n_checks++; if (cnt !== 20'd0) begin n_fail++; $display("FAIL midrst_cnt got %0d want 0", cnt); end
    n_checks++; if ({ol, om, os} !== 48'h0) begin n_fail++; $display("FAIL midrst_lms got %h %h %h want 0", ol, om, os); end
    @(negedge clk);
    rst = 1'b1; rdy_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL midrst_after cyc %0d got %b want 0", k, ovalid); end
    end
    n_checks++; if (cnt !== 20'd0) begin n_fail++; $display("FAIL midrst_cnt_after got %0d want 0", cnt); end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    rst3 = 1'b0; valid3 = 1'b0; last3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) begin
        @(negedge clk);
        n_checks++;
        if (cnt3 !== 3'((k < 7) ? k : 7)) begin
          n_fail++; $display("FAIL sat_cnt step %0d got %0d want %0d", k, cnt3, (k < 7) ? k : 7);
        end
      end
      valid3 = (k < 9);
    end
    valid3 = 1'b0;
  endtask

  initial begin
    rst3 = 1'b0; valid3 = 1'b0; last3 = 1'b0; rdy_in3 = 1'b1;
    test_reset();
    test_single(8'd0,   8'd0,   8'd0,   16'h0000, 16'h0000, 16'h0000, "black");
    test_single(8'd255, 8'd255, 8'd255, 16'hFEC0, 16'hFEC0, 16'hFE80, "white");
    test_single(8'd255, 8'd0,   8'd0,   16'h611E, 16'h320D, 16'h0639, "red");
    test_back_to_back();
    test_frame();
    test_reset_midflight();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
